// File: rtl/nav_pkg.sv
// Shared navigation constants: motion state codes and turn-direction encoding.
package nav_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_FWD    = 4'b0001,
    ST_DECIDE = 4'b0010,
    ST_EXIT   = 4'b0011,
    ST_GAP    = 4'b0100,
    ST_TURN_L = 4'b0111,
    ST_TURN_R = 4'b1001,
    ST_FAULT  = 4'b1111
  } nav_state_t;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Non-turn gap between the two halves of a U-turn
  localparam int unsigned GAP_MS = 2;

  function automatic logic is_turn(input nav_state_t s);
    return (s == ST_TURN_L) || (s == ST_TURN_R);
  endfunction

endpackage

// File: rtl/nav_timer.sv
// Saturating state-dwell counter with synchronous clear and limit compare.
module nav_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk_ms,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Count cycles spent in the current state; hold at all-ones instead of wrapping
  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // limit is the index of the last cycle the state may occupy
  assign expired = (cnt >= limit);

endmodule

// File: rtl/auto_nav_ctrl.sv
// Autonomous navigation sequencer: junction detection, settle, decide, turn, exit.
module auto_nav_ctrl
  import nav_pkg::*;
#(
  parameter int SETTLE_MS       = 200,
  parameter int EXIT_MS         = 500,
  parameter int TURN_TIMEOUT_MS = 2000,
  parameter int CNT_W           = 12
) (
  input  logic       clk_ms,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic       finish_turning,
  output logic [3:0] state,
  output logic       left_right,
  output logic       move_forward,
  output logic       brake,
  output logic       fault
);

  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_MS - 1);
  localparam logic [CNT_W-1:0] EXIT_LIM   = CNT_W'(EXIT_MS - 1);
  localparam logic [CNT_W-1:0] TURN_LIM   = CNT_W'(TURN_TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(GAP_MS - 1);

  nav_state_t       st, nxt;
  logic             uturn, uturn_nxt;
  logic             clr, expired;
  logic [CNT_W-1:0] limit;

  nav_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_ms  (clk_ms),
    .rst_n   (rst_n),
    .clr     (clr),
    .limit   (limit),
    .expired (expired)
  );

  // Next-state, U-turn flag and per-state timer limit
  always_comb begin
    nxt       = st;
    uturn_nxt = uturn;
    limit     = '1;
    case (st)
      ST_DECIDE:            limit = SETTLE_LIM;
      ST_GAP:               limit = GAP_LIM;
      ST_EXIT:              limit = EXIT_LIM;
      ST_TURN_L, ST_TURN_R: limit = TURN_LIM;
      default:              limit = '1;
    endcase

    if (!enable) begin
      nxt       = ST_IDLE;
      uturn_nxt = 1'b0;
    end else begin
      case (st)
        ST_IDLE: nxt = ST_FWD;
        ST_FWD: begin
          if (front_detector || !left_detector || !right_detector) nxt = ST_DECIDE;
        end
        ST_DECIDE: begin
          if (expired) begin
            if (!right_detector)      nxt = ST_TURN_R;
            else if (!front_detector) nxt = ST_EXIT;
            else if (!left_detector)  nxt = ST_TURN_L;
            else begin
              nxt       = ST_TURN_R;
              uturn_nxt = 1'b1;
            end
          end
        end
        ST_TURN_L, ST_TURN_R: begin
          // finish_turning takes priority over a coincident timeout
          if (finish_turning) begin
            if (uturn && (st == ST_TURN_R)) begin
              nxt       = ST_GAP;
              uturn_nxt = 1'b0;
            end else begin
              nxt = ST_EXIT;
            end
          end else if (expired) begin
            nxt       = ST_FAULT;
            uturn_nxt = 1'b0;
          end
        end
        ST_GAP:   if (expired) nxt = ST_TURN_R;
        ST_EXIT:  if (expired) nxt = ST_FWD;
        ST_FAULT: nxt = ST_FAULT;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  assign clr = (nxt != st) || !enable;

  // State, U-turn flag and outputs registered together, outputs decoded from next state
  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ST_IDLE;
      uturn        <= 1'b0;
      left_right   <= LR_LEFT;
      move_forward <= 1'b0;
      brake        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      st           <= nxt;
      uturn        <= uturn_nxt;
      left_right   <= (nxt == ST_TURN_R) ? LR_RIGHT : LR_LEFT;
      move_forward <= (nxt == ST_FWD) || (nxt == ST_EXIT);
      brake        <= (nxt == ST_DECIDE) || (nxt == ST_GAP);
      fault        <= (nxt == ST_FAULT);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_auto_nav_ctrl.sv
// Scoreboard bench: stimulus queues expected output changes with dwell times,
// a negedge monitor compares every observed change of the output vector.
module tb_auto_nav_ctrl;

  // Output vector layout: {state[3:0], left_right, move_forward, brake, fault}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_FWD  = 8'b0001_0100;
  localparam logic [7:0] V_DEC  = 8'b0010_0010;
  localparam logic [7:0] V_EXIT = 8'b0011_0100;
  localparam logic [7:0] V_GAP  = 8'b0100_0010;
  localparam logic [7:0] V_TL   = 8'b0111_0000;
  localparam logic [7:0] V_TR   = 8'b1001_1000;
  localparam logic [7:0] V_FLT  = 8'b1111_0001;

  typedef struct {
    string      name;
    logic [7:0] vec;
    int         dwell;   // cycles the previous vector must have lasted; -1 = don't care
  } exp_t;

  logic       clk_ms = 1'b0;
  logic       rst_n  = 1'b1;
  logic       enable = 1'b0;
  logic       front_detector = 1'b0;
  logic       left_detector  = 1'b1;
  logic       right_detector = 1'b1;
  logic       finish_turning = 1'b0;
  logic [3:0] state;
  logic       left_right, move_forward, brake, fault;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  auto_nav_ctrl #(
    .SETTLE_MS       (200),
    .EXIT_MS         (500),
    .TURN_TIMEOUT_MS (2000),
    .CNT_W           (12)
  ) dut (
    .clk_ms         (clk_ms),
    .rst_n          (rst_n),
    .enable         (enable),
    .front_detector (front_detector),
    .left_detector  (left_detector),
    .right_detector (right_detector),
    .finish_turning (finish_turning),
    .state          (state),
    .left_right     (left_right),
    .move_forward   (move_forward),
    .brake          (brake),
    .fault          (fault)
  );

  always #5 clk_ms = ~clk_ms;

  function automatic logic [7:0] outv();
    return {state, left_right, move_forward, brake, fault};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, want, want, $time);
  endtask

  task automatic push(input string nm, input logic [7:0] v, input int d);
    exp_t e;
    e.name = nm; e.vec = v; e.dwell = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_ms);
    #1;
  endtask

  // Monitor: every change of the output vector consumes one expectation
  initial begin
    logic [7:0] prev, cur;
    int         dwell;
    exp_t       e;
    prev  = V_IDLE;
    dwell = 0;
    forever begin
      @(negedge clk_ms);
      cur = outv();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_vec"}, 32'(cur), 32'(e.vec));
          if (e.dwell >= 0) chk({e.name, "_prev_dwell"}, 32'(dwell), 32'(e.dwell));
        end
        prev  = cur;
        dwell = 1;
      end else begin
        dwell++;
      end
    end
  end

  // Stimulus
  initial begin
    logic found;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 32'(outv()), 32'(V_IDLE));
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    // Corridor: forward and stay there
    push("corridor_fwd", V_FWD, -1);
    enable = 1'b1;
    cyc(50);

    // Right junction
    push("rj_decide", V_DEC, -1);
    push("rj_turn_r", V_TR, 200);
    right_detector = 1'b0;
    cyc(210);
    right_detector = 1'b1;
    push("rj_exit", V_EXIT, -1);
    push("rj_fwd", V_FWD, 500);
    finish_turning = 1'b1;
    cyc(1);
    finish_turning = 1'b0;
    cyc(520);

    // Dead end: U-turn with finish_turning held across GAP
    push("de_decide", V_DEC, -1);
    push("de_turn_r1", V_TR, 200);
    front_detector = 1'b1;
    cyc(205);
    front_detector = 1'b0;
    push("de_gap", V_GAP, -1);
    push("de_turn_r2", V_TR, 2);
    finish_turning = 1'b1;
    cyc(3);
    finish_turning = 1'b0;
    cyc(10);
    push("de_exit", V_EXIT, -1);
    push("de_fwd", V_FWD, 500);
    finish_turning = 1'b1;
    cyc(1);
    finish_turning = 1'b0;
    cyc(520);

    // Left turn timeout -> FAULT, cleared by enable
    push("to_decide", V_DEC, -1);
    push("to_turn_l", V_TL, 200);
    push("to_fault", V_FLT, 2000);
    front_detector = 1'b1;
    left_detector  = 1'b0;
    cyc(2210);
    push("to_idle", V_IDLE, -1);
    enable = 1'b0;
    cyc(3);
    front_detector = 1'b0;
    left_detector  = 1'b1;
    push("to_refwd", V_FWD, -1);
    enable = 1'b1;
    cyc(5);

    // finish_turning on the final timeout cycle wins
    push("sim_decide", V_DEC, -1);
    push("sim_turn_r", V_TR, 200);
    push("sim_exit", V_EXIT, 2000);
    push("sim_fwd", V_FWD, 500);
    right_detector = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (state == 4'b1001) begin
        found = 1'b1;
        break;
      end
    end
    chk("sim_turn_reached", 32'(found), 32'd1);
    right_detector = 1'b1;
    cyc(1999);
    finish_turning = 1'b1;
    cyc(1);
    finish_turning = 1'b0;
    cyc(520);

    // enable dropped mid-DECIDE
    push("en_decide", V_DEC, -1);
    push("en_idle", V_IDLE, 50);
    left_detector = 1'b0;
    cyc(50);
    enable = 1'b0;
    cyc(2);
    left_detector = 1'b1;
    push("en_refwd", V_FWD, -1);
    enable = 1'b1;
    cyc(5);

    // Reset mid-EXIT
    push("rs_decide", V_DEC, -1);
    push("rs_turn_r", V_TR, 200);
    right_detector = 1'b0;
    cyc(210);
    right_detector = 1'b1;
    push("rs_exit", V_EXIT, -1);
    finish_turning = 1'b1;
    cyc(1);
    finish_turning = 1'b0;
    cyc(100);
    push("rs_idle", V_IDLE, -1);
    enable = 1'b0;
    rst_n  = 1'b0;
    #1 chk("reset_mid_exit", 32'(outv()), 32'(V_IDLE));
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    push("rs_fwd", V_FWD, -1);
    enable = 1'b1;
    cyc(5);

    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/auto_nav_ctrl.md
# auto_nav_ctrl

Autonomous-mode navigation sequencer for the car. It watches the three obstacle detectors and decides forward, stop, turn or U-turn at each junction. It drives the 4-bit motion `state` bus and the `left_right` select consumed by the turn executor, and advances only when the executor reports `finish_turning`. It sits between the mode selector, which supplies `enable`, and the motion and turn datapath.

## Interface
- `SETTLE_MS`, 200: stop-and-settle cycles before sampling detectors at a junction; must be ≥2.
- `EXIT_MS`, 500: forward cycles after a turn or straight-through, to clear the junction.
- `TURN_TIMEOUT_MS`, 2000: maximum cycles in one turn state without `finish_turning`.
- `CNT_W`, 12: timer width; every parameter must be < 2^CNT_W.
- `clk_ms` input 1: 1 kHz system tick clock. Single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: auto mode active. Synchronous.
- `front_detector`, `left_detector`, `right_detector` input 1 each: 1 = obstacle present.
- `finish_turning` input 1: turn executor done. Held high while a turn code persists.
- `state` output 4: registered motion code.
- `left_right` output 1: 0 = left, 1 = right. Valid in turn states.
- `move_forward` output 1: high in FWD and EXIT.
- `brake` output 1: high in DECIDE and GAP.
- `fault` output 1: high in FAULT.

## Operation
- State codes: IDLE 4'b0000, FWD 4'b0001, DECIDE 4'b0010, EXIT 4'b0011, GAP 4'b0100, TURN_L 4'b0111, TURN_R 4'b1001, FAULT 4'b1111.
- IDLE: leave to FWD when `enable`=1.
- FWD: leave to DECIDE when `front_detector`=1 or `left_detector`=0 or `right_detector`=0.
- DECIDE lasts exactly SETTLE_MS cycles. Detectors are sampled on its last cycle, with priority:
  - right open → TURN_R
  - else front open → EXIT
  - else left open → TURN_L
  - else U-turn: TURN_R, GAP, TURN_R, then EXIT.
- TURN_L drives `left_right`=0; TURN_R drives `left_right`=1. On `finish_turning`=1: go to GAP if this is the first half of a U-turn, else to EXIT.
- GAP lasts exactly 2 cycles. This lets the executor see a non-turn code and clear its count and `finish_turning` before the next turn.
- EXIT lasts exactly EXIT_MS cycles, then goes to FWD. Detectors are ignored during EXIT.
- Turn timeout: TURN_TIMEOUT_MS consecutive cycles in one turn state with `finish_turning`=0 → FAULT.
- FAULT: all motion outputs 0, `fault`=1. Exits only via `enable`=0 (→ IDLE) or reset.
- `finish_turning` is ignored outside TURN_L and TURN_R.
- Every turn state is entered only from DECIDE (≥2 cycles) or GAP (2 cycles), so a stale `finish_turning` is never seen.

## Timing
- Reset: `state`=IDLE, `left_right`=0, `move_forward`=0, `brake`=0, `fault`=0, timer=0, U-turn flag=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as `state`.
- The decision is 1 cycle: detector sample on the last DECIDE cycle → turn or EXIT code on the next edge.
- The `finish_turning` response is 1 cycle: it is seen high at edge N, and GAP or EXIT is present after edge N.
- `enable`=0 in any state → IDLE at the next edge. The timer and U-turn flag clear; outputs go to reset values.
- Reset mid-turn returns immediately (asynchronously) to reset values.
- The timer reloads on every state change. It must not wrap: saturate at 2^CNT_W−1.
- Simultaneous timeout expiry and `finish_turning`=1 on the same cycle: `finish_turning` wins.

## Structure
- `nav_pkg`: the 4-bit state code constants listed above, plus the shared `left_right` encoding. The turn executor and motion decoder reference the same constants.
- Sub-module `nav_timer`: CNT_W-bit up-counter with synchronous clear and an `expired` compare against a loaded limit. One instance is shared by DECIDE, GAP, EXIT and the turn timeout.
- Top level: FSM, U-turn flag, output register.

## Test plan
- Corridor: `enable`=1, F=0/L=1/R=1 → `state`=0001, `move_forward`=1, held indefinitely.
- Right junction: drop R to 0 → 0010 for exactly 200 cycles, then 1001 with `left_right`=1. Pulse `finish_turning` → 0011 for 500 cycles → 0001.
- Dead end: F=1/L=1/R=1 at decision → 1001, finish → 0100 for 2 cycles → 1001, finish → 0011. Check `finish_turning` is ignored during GAP.
- Timeout: enter TURN_L and hold `finish_turning`=0 for 2000 cycles → 1111, `fault`=1. Drop `enable` → 0000.
- Simultaneous events: `finish_turning` rises on cycle 2000 of a turn → EXIT, not FAULT. Drop `enable` mid-DECIDE → 0000 next edge.
- Reset: assert `rst_n`=0 mid-EXIT → all outputs 0 immediately. Release → IDLE, then FWD once `enable`=1.
